frame_store_fwd: RTL and testbench
==================================

// Module: frame_store_fwd
// PURPOSE
//  Single-clock store-and-forward Ethernet frame buffer: a parametrised successor of the rx data FIFO plus frame-length FIFO pair.
//  Accepts MAC rx beats and commits a frame only when it completes good; discards bad, oversize and overflowed frames.
//  Presents committed frames with their length to the tx controller over a valid/ready stream.
//  Raises a pause request from a free-space watermark.
// PARAMETERS
//  DW          8     data beat width, bits
//  DEPTH       2048  data RAM entries; power of 2
//  MAX_FRAMES  16    length-queue entries; power of 2
//  MAX_LEN     1518  maximum beats per frame; longer frames are dropped
//  PAUSE_TH    256   assert pause_req when free entries < PAUSE_TH
// PORTS
//  clk        in   1         single clock
//  rst        in   1         asynchronous, active-high reset
//  in_data    in   DW        rx beat
//  in_valid   in   1         beat present; no backpressure
//  in_last    in   1         final beat of frame, qualified by in_valid
//  in_err     in   1         frame bad (FCS/phy error); sampled with in_last
//  out_data   out  DW        tx beat
//  out_valid  out  1         beat available
//  out_last   out  1         final beat of current frame
//  out_len    out  16        beat count of current frame; stable while out_valid
//  out_ready  in   1         sink accepts beat when out_valid&&out_ready
//  pause_req  out  1         level; free space below PAUSE_TH
//  frm_cnt    out  $clog2(MAX_FRAMES)+1  committed, unsent frames
//  drop_cnt   out  16        dropped frames, saturating
// BEHAVIOUR
//  Reset: all pointers/counters 0; out_valid=0, out_last=0, out_data=0, out_len=0, pause_req=0, frm_cnt=0, drop_cnt=0.
//  Write side:
//   - wr_ptr advances per accepted beat; cmt_ptr holds the start of the current frame.
//   - beat_cnt counts beats in frame; length = beat_cnt+1 at in_last.
//   - Poison flag set if the beat arrives with RAM full, beat_cnt==MAX_LEN, or the length queue is full at in_last.
//   - Poisoned beats are not written.
//   - On in_last: good && !poison -> cmt_ptr<=wr_ptr+1, push length, frm_cnt++.
//     Otherwise wr_ptr<=cmt_ptr (rewind), drop_cnt++ (saturating at 16'hFFFF). Poison clears.
//   - Full = (wr_ptr+1)==rd_ptr, modulo DEPTH; pointers wrap naturally.
//  Read side FSM (states IDLE, LOAD, XFER):
//   - IDLE: frm_cnt!=0 -> LOAD; issue RAM read at rd_ptr; pop length into out_len.
//   - LOAD: 1-cycle RAM latency; register data; out_valid<=1 -> XFER.
//   - XFER: on handshake rd_ptr++, rem--.
//     - rem reaches 0 -> frame done, frm_cnt--, out_valid<=0, state IDLE.
//     - else prefetch so that back-to-back beats stream at 1 beat/clk under continuous out_ready.
//   - out_last = out_valid && (rem==1).
//   - out_valid held, data stable, while !out_ready.
//  Latency: a frame committed at cycle T (in_last) yields out_valid at T+3 when idle.
//  Simultaneous commit and pop in one cycle: frm_cnt unchanged, both take effect.
//  Free space is measured against rd_ptr (not cmt_ptr); uncommitted beats count as used.
//  pause_req registered, updated every cycle.
//  Frame of exactly MAX_LEN beats is accepted; MAX_LEN+1 is dropped.
//  Reset mid-frame on either side: everything discarded, no partial frame emitted afterwards.
//  in_last with in_valid=0 is ignored.
// STRUCTURE
//  Package eth_buf_pkg:
//   - typedef rd_state_t {IDLE,LOAD,XFER}
//   - typedef len_t logic[15:0]
//   - localparams for pointer widths computed from DEPTH/MAX_FRAMES
//  Sub-module sdp_ram (DW x DEPTH, simple dual port, registered read) used for data.
//  Length queue is a small register-array FIFO inside this block.
// TESTING
//  - Good 64-beat frame, data 0..63, out_ready=1 -> one frame, out_len=64, out_last on beat 63, frm_cnt 1->0, drop_cnt=0.
//  - 64-beat frame with in_err at last, then good 60-byte frame -> only 60-beat frame emitted, drop_cnt=1, no stale data.
//  - DEPTH=64: 40-beat frame, then 40-beat frame, out_ready=0 -> second frame dropped; pause_req asserts once free<PAUSE_TH.
//  - MAX_LEN=1518: frames of 1518 and 1519 beats -> first emitted, second dropped, drop_cnt=1.
//  - MAX_FRAMES=4: 5 back-to-back 64-beat frames, out_ready=0 -> frm_cnt=4, drop_cnt=1.
//    Then out_ready toggling 1/0 -> 4 frames intact, in order.
//  - Assert rst mid-XFER of a 100-beat frame -> out_valid=0 next edge, frm_cnt=0; subsequent good frame emitted correctly.

Source files
------------

// File: rtl/eth_buf_pkg.sv
// Shared types and sizing helpers for the store-and-forward frame buffer.
package eth_buf_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, XFER} rd_state_t;
  typedef logic [15:0] len_t;

  localparam int DEF_DEPTH      = 2048;
  localparam int DEF_MAX_FRAMES = 16;
  localparam int DEF_AW         = $clog2(DEF_DEPTH);
  localparam int DEF_LW         = $clog2(DEF_MAX_FRAMES);

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
module sdp_ram
  import eth_buf_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/frame_store_fwd.sv
// Store-and-forward frame buffer: commits only good complete frames, replays
// them with their length over a valid/ready stream, and flags low free space.
module frame_store_fwd
  import eth_buf_pkg::*;
#(
  parameter int DW         = 8,
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 16,
  parameter int MAX_LEN    = 1518,
  parameter int PAUSE_TH   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic                          in_err,
  output logic [DW-1:0]                 out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output len_t                          out_len,
  input  logic                          out_ready,
  output logic                          pause_req,
  output logic [$clog2(MAX_FRAMES):0]   frm_cnt,
  output logic [15:0]                   drop_cnt
);
  localparam int AW = ptr_w(DEPTH);
  localparam int LW = ptr_w(MAX_FRAMES);
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] TWO  = AW'(2);
  localparam logic [AW-1:0] MAXF = AW'(DEPTH - 1);
  localparam logic [31:0]   PTH  = 32'(PAUSE_TH);

  logic [AW-1:0] wr_ptr, cmt_ptr, rd_ptr, rd_addr, wr_inc, used, free;
  len_t          beat_cnt, rem;
  logic          poison;
  len_t          lq_mem [MAX_FRAMES];
  logic [LW-1:0] lq_wp, lq_rp;
  rd_state_t     state, state_nxt;
  logic [DW-1:0] ram_q;
  logic          ram_full, lq_full, bad_beat, poison_now, wr_en;
  logic          commit, pop, hs, done;

  // Write side: a beat is poisoned once the frame can no longer be stored.
  // frm_cnt still counts the frame being sent, so it gates queue admission.
  assign wr_inc     = wr_ptr + ONE;
  assign ram_full   = wr_inc == rd_ptr;
  assign lq_full    = frm_cnt == FW'(MAX_FRAMES);
  assign bad_beat   = ram_full || (beat_cnt == len_t'(MAX_LEN)) || (in_last && lq_full);
  assign poison_now = poison || bad_beat;
  assign wr_en      = in_valid && !poison_now;
  assign commit     = in_valid && in_last && !in_err && !poison_now;

  sdp_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      beat_cnt <= '0;
      poison   <= 1'b0;
      lq_wp    <= '0;
      drop_cnt <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        beat_cnt <= '0;
        poison   <= 1'b0;
        if (commit) begin
          wr_ptr  <= wr_inc;
          cmt_ptr <= wr_inc;
          lq_wp   <= lq_wp + 1'b1;
        end else begin
          wr_ptr <= cmt_ptr;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end else begin
        poison <= poison_now;
        if (wr_en) wr_ptr <= wr_inc;
        if (beat_cnt != len_t'(MAX_LEN)) beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) lq_mem[lq_wp] <= beat_cnt + 16'd1;
  end

  // Read side: the RAM always fetches one beat ahead of out_data so a
  // handshake can refill out_data from ram_q every cycle.
  assign hs       = out_valid && out_ready;
  assign done     = hs && (rem == 16'd1);
  assign out_last = out_valid && (rem == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rd_addr   = rd_ptr + ONE;
    case (state)
      IDLE: begin
        rd_addr = rd_ptr;
        if (frm_cnt != '0) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = XFER;
      XFER: if (hs) begin
        rd_addr = rd_ptr + TWO;
        if (rem == 16'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      rem       <= '0;
      out_len   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      lq_rp     <= '0;
    end else begin
      if (pop) begin
        out_len <= lq_mem[lq_rp];
        rem     <= lq_mem[lq_rp];
        lq_rp   <= lq_rp + 1'b1;
      end
      if (state == LOAD) begin
        out_data  <= ram_q;
        out_valid <= 1'b1;
      end
      if (hs) begin
        rd_ptr <= rd_ptr + ONE;
        rem    <= rem - 16'd1;
        if (rem == 16'd1) out_valid <= 1'b0;
        else              out_data  <= ram_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frm_cnt <= '0;
    else case ({commit, done})
      2'b10:   frm_cnt <= frm_cnt + 1'b1;
      2'b01:   frm_cnt <= frm_cnt - 1'b1;
      default: frm_cnt <= frm_cnt;
    endcase
  end

  // Uncommitted beats count as used, so pause reacts to the frame in flight.
  assign used = wr_ptr - rd_ptr;
  assign free = MAXF - used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_req <= 1'b0;
    else     pause_req <= 32'(free) < PTH;
  end
endmodule

// File: tb/tb_frame_store_fwd.sv
// Scoreboard bench for frame_store_fwd: beats of frames expected to commit are
// queued at drive time and compared as the DUT hands them out.
module tb_frame_store_fwd;
  localparam int DW = 8, DEPTH = 2048, MAX_FRAMES = 4, MAX_LEN = 1518, PAUSE_TH = 256;
  localparam int FW = $clog2(MAX_FRAMES) + 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, in_err = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_ready = 1'b0, pause_req;
  logic [15:0]   out_len, drop_cnt;
  logic [FW-1:0] frm_cnt;

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [15:0] n;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    nchk = 0, nerr = 0;
  bit    pause_seen = 1'b0;

  frame_store_fwd #(
    .DW(DW), .DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES), .MAX_LEN(MAX_LEN), .PAUSE_TH(PAUSE_TH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_err(in_err),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_len(out_len),
    .out_ready(out_ready), .pause_req(pause_req), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int base, input bit err, input bit exp_ok);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = 8'((base + i) & 'hFF);
      in_last  = (i == len - 1);
      in_err   = err && (i == len - 1);
      if (exp_ok) exp_q.push_back('{d: 8'((base + i) & 'hFF), l: (i == len - 1), n: 16'(len)});
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget, input bit toggle);
    int n = 0;
    while ((exp_q.size() != 0 || frm_cnt != '0 || out_valid) && n < budget) begin
      if (toggle) out_ready = ~out_ready;
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    if (pause_req) pause_seen = 1'b1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
        chk("out_len",  32'(out_len),  32'(e.n));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_len",   32'(out_len),   0);
    chk("rst_pause",     32'(pause_req), 0);
    chk("rst_frm_cnt",   32'(frm_cnt),   0);
    chk("rst_drop_cnt",  32'(drop_cnt),  0);

    // good 64-beat frame, commit-to-valid latency
    out_ready = 1'b1;
    send_frame(64, 0, 1'b0, 1'b1);
    chk("t1_frm_cnt_1", 32'(frm_cnt), 1);
    chk("t1_valid_T1", 32'(out_valid), 0);
    step();
    chk("t1_valid_T2", 32'(out_valid), 0);
    step();
    chk("t1_valid_T3", 32'(out_valid), 1);
    wait_drain("t1_drain", 200, 1'b0);
    chk("t1_frm_cnt_0", 32'(frm_cnt), 0);
    chk("t1_drop_cnt", 32'(drop_cnt), 0);

    // errored frame then good 60-beat frame
    send_frame(64, 8'h80, 1'b1, 1'b0);
    send_frame(60, 8'h10, 1'b0, 1'b1);
    wait_drain("t2_drain", 200, 1'b0);
    chk("t2_drop_cnt", 32'(drop_cnt), 1);

    // RAM overflow with sink stalled; pause asserts while space runs out
    out_ready  = 1'b0;
    pause_seen = 1'b0;
    send_frame(1200, 8'h20, 1'b0, 1'b1);
    step();
    chk("t3_no_pause_first", 32'(pause_seen), 0);
    send_frame(1200, 8'h55, 1'b0, 1'b0);
    chk("t3_pause_seen", 32'(pause_seen), 1);
    chk("t3_frm_cnt", 32'(frm_cnt), 1);
    chk("t3_drop_cnt", 32'(drop_cnt), 2);
    step();
    step();
    chk("t3_pause_released", 32'(pause_req), 0);
    out_ready = 1'b1;
    wait_drain("t3_drain", 1400, 1'b0);

    // MAX_LEN boundary
    send_frame(MAX_LEN, 8'h03, 1'b0, 1'b1);
    send_frame(MAX_LEN + 1, 8'h07, 1'b0, 1'b0);
    wait_drain("t4_drain", 2000, 1'b0);
    chk("t4_drop_cnt", 32'(drop_cnt), 3);

    // length queue full with sink stalled, then toggling ready
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(64, 16 * k + 1, 1'b0, (k < 4));
    step();
    chk("t5_frm_cnt", 32'(frm_cnt), 4);
    chk("t5_drop_cnt", 32'(drop_cnt), 4);
    wait_drain("t5_drain", 1200, 1'b1);
    chk("t5_frm_cnt_0", 32'(frm_cnt), 0);

    // reset in the middle of a transfer
    out_ready = 1'b1;
    send_frame(100, 8'h40, 1'b0, 1'b1);
    repeat (23) step();
    chk("t6_mid_xfer", 32'(out_valid), 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_frm_cnt", 32'(frm_cnt), 0);
    step();
    chk("t6_rst_valid_edge", 32'(out_valid), 0);
    chk("t6_rst_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    step();
    send_frame(30, 8'hC0, 1'b0, 1'b1);
    wait_drain("t6_drain", 200, 1'b0);
    chk("t6_drop_cnt_end", 32'(drop_cnt), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
